// File: rtl/instruction_fetch_stage_if.sv
// Instruction-memory request/acknowledge port of the IF stage.
// Only one request is outstanding at a time, and the address is held until imem_ack.
interface instruction_fetch_stage_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
    modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/instruction_fetch_stage.sv
// IF stage of the 16-bit MIPS core: PC, single-outstanding fetch, one-entry skid buffer,
// and the IF/ID register that feeds control_unit.
module instruction_fetch_stage #(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instruction_fetch_stage_if.master imem,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [ADDR_W-1:0]    redirect_pc,
    output logic                 if_valid,
    output logic [INSTR_W-1:0]   if_instr,
    output logic [5:0]           if_opcode,
    output logic [ADDR_W-1:0]    if_pc,
    output logic [ADDR_W-1:0]    if_pc_plus1
);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    typedef enum logic [1:0] {BOOT, FETCH, SKID, FLUSH} fetchState_e;

    fetchState_e        state,     stateNext;
    logic [ADDR_W-1:0]  pc,        pcNext;
    logic [ADDR_W-1:0]  target,    targetNext;
    logic               ifValid,   ifValidNext;
    logic [INSTR_W-1:0] ifInstr,   ifInstrNext;
    logic [ADDR_W-1:0]  ifPc,      ifPcNext;
    logic [INSTR_W-1:0] skidInstr, skidInstrNext;
    logic [ADDR_W-1:0]  skidPc,    skidPcNext;

    assign imem.imem_req  = (state == FETCH) || (state == FLUSH);
    assign imem.imem_addr = pc;

    assign if_valid    = ifValid;
    assign if_instr    = ifInstr;
    assign if_opcode   = ifInstr[INSTR_W-1 -: 6];
    assign if_pc       = ifPc;
    assign if_pc_plus1 = ifPc + STEP;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        stateNext     = state;
        pcNext        = pc;
        targetNext    = target;
        ifValidNext   = ifValid;
        ifInstrNext   = ifInstr;
        ifPcNext      = ifPc;
        skidInstrNext = skidInstr;
        skidPcNext    = skidPc;

        case (state)
            BOOT: begin
                stateNext = FETCH;
                if (redirect_valid) pcNext = redirect_pc;
            end
            FETCH: begin
                if (redirect_valid) begin
                    ifValidNext = 1'b0;
                    ifInstrNext = '0;
                    if (imem.imem_ack) begin
                        pcNext = redirect_pc;
                    end else begin
                        // The in-flight request must still complete; its data is dropped in FLUSH.
                        targetNext = redirect_pc;
                        stateNext  = FLUSH;
                    end
                end else if (imem.imem_ack) begin
                    pcNext = pc + STEP;
                    if (stall && ifValid) begin
                        skidInstrNext = imem.imem_rdata;
                        skidPcNext    = pc;
                        stateNext     = SKID;
                    end else begin
                        ifValidNext = 1'b1;
                        ifInstrNext = imem.imem_rdata;
                        ifPcNext    = pc;
                    end
                end else if (!stall) begin
                    // ID consumed the current entry and nothing replaced it: insert a bubble.
                    ifValidNext = 1'b0;
                    ifInstrNext = '0;
                end
            end
            SKID: begin
                if (redirect_valid) begin
                    pcNext      = redirect_pc;
                    ifValidNext = 1'b0;
                    ifInstrNext = '0;
                    stateNext   = FETCH;
                end else if (!stall) begin
                    ifValidNext = 1'b1;
                    ifInstrNext = skidInstr;
                    ifPcNext    = skidPc;
                    stateNext   = FETCH;
                end
            end
            FLUSH: begin
                if (redirect_valid) targetNext = redirect_pc;
                if (imem.imem_ack) begin
                    pcNext    = redirect_valid ? redirect_pc : target;
                    stateNext = FETCH;
                end
            end
            default: stateNext = BOOT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            pc        <= RESET_PC;
            target    <= RESET_PC;
            ifValid   <= 1'b0;
            ifInstr   <= '0;
            ifPc      <= '0;
            skidInstr <= '0;
            skidPc    <= '0;
        end else begin
            state     <= stateNext;
            pc        <= pcNext;
            target    <= targetNext;
            ifValid   <= ifValidNext;
            ifInstr   <= ifInstrNext;
            ifPc      <= ifPcNext;
            skidInstr <= skidInstrNext;
            skidPc    <= skidPcNext;
        end
    end
endmodule
